// File: rtl/bch_syndrome_scan_pkg.sv
`default_nettype none
// ============================================================================
// bch_syndrome_scan_pkg : state encoding and width helpers for the scan block
// Revision 1.0
// ============================================================================
package bch_syndrome_scan_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_SCAN = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   function automatic int num_groups(input int t, input int lanes);
      return (t + lanes - 1) / lanes;
   endfunction

   function automatic int idx_w(input int t);
      return (t > 1) ? $clog2(t) : 1;
   endfunction

   function automatic int cnt_w(input int t);
      return $clog2(t + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/bch_syndrome_scan_if.sv
`default_nettype none
// ============================================================================
// bch_syndrome_scan_if : syndrome-in / result-out handshake bundle
// Revision 1.0
// ============================================================================
interface bch_syndrome_scan_if #(
   parameter int M = 4,
   parameter int T = 4
);
   import bch_syndrome_scan_pkg::*;

   logic                  in_valid;
   logic                  in_ready;
   logic [M*T-1:0]        syn_in;
   logic                  out_valid;
   logic                  out_ready;
   logic                  err;
   logic [idx_w(T)-1:0]   first_nz;
   logic [cnt_w(T)-1:0]   nz_count;

   modport master (
      output in_valid, syn_in, out_ready,
      input  in_ready, out_valid, err, first_nz, nz_count
   );

   modport slave (
      input  in_valid, syn_in, out_ready,
      output in_ready, out_valid, err, first_nz, nz_count
   );
endinterface
`default_nettype wire

// File: rtl/bch_syndrome_scan_syn_lane_nonzero.sv
`default_nettype none
// ============================================================================
// syn_lane_nonzero : one-lane M-bit nonzero detector (OR carry chain), gated
//                    by a lane-valid input so padding lanes read as zero.
// Revision 1.0
// ============================================================================
module syn_lane_nonzero #(
   parameter int M = 4
) (
   input  logic         lane_valid,
   input  logic [M-1:0] data,
   output logic         nonzero
);

   logic [M:0] chain;

   always_comb begin
      chain    = '0;
      for (int b = 0; b < M; b++) begin
         chain[b+1] = chain[b] | data[b];
      end
   end

   assign nonzero = lane_valid & chain[M];

endmodule
`default_nettype wire

// File: rtl/bch_syndrome_scan.sv
`default_nettype none
// ============================================================================
// bch_syndrome_scan : scans a captured syndrome vector LANES at a time and
//                     reports err / first nonzero index / nonzero count.
// Revision 1.0
// ============================================================================
module bch_syndrome_scan
   import bch_syndrome_scan_pkg::*;
#(
   parameter int M          = 4,
   parameter int T          = 4,
   parameter int LANES      = 2,
   parameter int EARLY_EXIT = 0
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               clear,
   bch_syndrome_scan_if.slave bus
);

   localparam int G    = num_groups(T, LANES);
   localparam int GW   = idx_w(G);
   localparam int IW   = idx_w(T);
   localparam int CW   = cnt_w(T);
   localparam int PADW = M * G * LANES;

   state_t          state;
   logic [GW-1:0]   grp;
   logic [M*T-1:0]  syn_q;
   logic            err_q;
   logic [IW-1:0]   first_q;
   logic [CW-1:0]   cnt_q;

   logic [PADW-1:0] syn_pad;
   logic [M-1:0]    lane_data [LANES];
   logic [LANES-1:0] lane_valid;
   logic [LANES-1:0] lane_nz;
   logic [CW-1:0]   pop;
   logic [IW-1:0]   first_idx;
   logic            any_nz;
   logic            last_grp;

   // Zero-extend so the final group can always be sliced at full width.
   assign syn_pad = PADW'(syn_q);

   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         lane_data[l]  = syn_pad[(int'(grp) * LANES + l) * M +: M];
         lane_valid[l] = (int'(grp) * LANES + l) < T;
      end
   end

   generate
      for (genvar l = 0; l < LANES; l++) begin : g_lane
         syn_lane_nonzero #(.M(M)) u_nz (
            .lane_valid (lane_valid[l]),
            .data       (lane_data[l]),
            .nonzero    (lane_nz[l])
         );
      end
   endgenerate

   // Descending walk so the lowest flagged lane wins the index.
   always_comb begin
      pop       = '0;
      first_idx = '0;
      for (int l = LANES - 1; l >= 0; l--) begin
         pop = pop + CW'(lane_nz[l]);
         if (lane_nz[l]) begin
            first_idx = IW'(int'(grp) * LANES + l);
         end
      end
   end

   assign any_nz   = |lane_nz;
   assign last_grp = (grp == GW'(G - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         grp     <= '0;
         syn_q   <= '0;
         err_q   <= 1'b0;
         first_q <= '0;
         cnt_q   <= '0;
      end else if (clear) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  syn_q   <= bus.syn_in;
                  grp     <= '0;
                  err_q   <= 1'b0;
                  first_q <= '0;
                  cnt_q   <= '0;
                  state   <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               cnt_q <= cnt_q + pop;
               if (!err_q && any_nz) begin
                  err_q   <= 1'b1;
                  first_q <= first_idx;
               end
               if (last_grp || ((EARLY_EXIT != 0) && any_nz)) begin
                  state <= ST_DONE;
               end else begin
                  grp <= grp + 1'b1;
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == ST_IDLE);
   assign bus.out_valid = (state == ST_DONE);
   assign bus.err       = err_q;
   assign bus.first_nz  = first_q;
   assign bus.nz_count  = cnt_q;

endmodule
`default_nettype wire
